dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader
//  port (DBG). Serialises accesses over a fixed-latency memory and stalls the pipeline until its
//  access completes. A bounded-streak rule stops CPU traffic from starving DBG.
// PARAMETERS
//  ADDR_W          32  address width, passed through unchanged
//  DATA_W          32  data width
//  MEM_LAT         2   cycles from ISSUE to valid mem_rdata_i; legal values are >= 1
//  MAX_CPU_STREAK  4   consecutive CPU grants allowed while DBG waits; legal values are >= 1
// PORTS
//  clk_i         in   1       clock; all state updates on the rising edge
//  rst_i         in   1       synchronous, active-high reset
//  cpu_req_i     in   1       MEM stage needs a load or store; held until the RESP cycle
//  cpu_we_i      in   1       1 = store
//  cpu_addr_i    in   ADDR_W  access address
//  cpu_wdata_i   in   DATA_W  store data
//  cpu_rdata_o   out  DATA_W  load data; valid in CPU RESP cycle, 0 otherwise
//  cpu_stall_o   out  1       freeze pipeline (combinational)
//  dbg_req_i     in   1       DBG access request; held until dbg_gnt_o
//  dbg_we_i      in   1       1 = write
//  dbg_addr_i    in   ADDR_W  access address
//  dbg_wdata_i   in   DATA_W  write data
//  dbg_gnt_o     out  1       1-cycle pulse: DBG request consumed (ISSUE cycle)
//  dbg_rvalid_o  out  1       1-cycle pulse: DBG access complete
//  dbg_rdata_o   out  DATA_W  read data; valid with dbg_rvalid_o, 0 otherwise
//  mem_en_o      out  1       memory strobe; high only in ISSUE
//  mem_we_o      out  1       write strobe; high only in ISSUE for a write
//  mem_addr_o    out  ADDR_W  latched address, held from ISSUE through RESP
//  mem_wdata_o   out  DATA_W  latched write data, held from ISSUE through RESP
//  mem_rdata_i   in   DATA_W  memory read data; valid exactly MEM_LAT cycles after ISSUE
// BEHAVIOUR
//  - States: IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles; skipped when MEM_LAT=1) -> RESP -> IDLE.
//  - IDLE, arbitration:
//      - if any request: latch the winner's we/addr/wdata and owner; go to ISSUE.
//      - winner is CPU, except DBG when cpu_req_i=0, or when both request and streak==MAX_CPU_STREAK.
//  - Streak counter:
//      - +1 on each CPU grant made while dbg_req_i=1.
//      - cleared on a DBG grant, and in any IDLE cycle with dbg_req_i=0.
//      - saturates at MAX_CPU_STREAK.
//  - ISSUE: mem_en_o=1, mem_we_o=latched we; dbg_gnt_o=1 if the owner is DBG.
//      - The DBG requester may change its inputs from the next cycle on.
//  - RESP, by owner:
//      - CPU: cpu_rdata_o=mem_rdata_i, cpu_stall_o=0.
//      - DBG: dbg_rvalid_o=1, dbg_rdata_o=mem_rdata_i.
//      - Writes also pass through RESP, as the completion ack.
//  - Stall:
//      - cpu_stall_o = cpu_req_i & ~(state==RESP & owner==CPU).
//      - Stall is also high while DBG owns the memory.
//  - Timing:
//      - CPU access latency is MEM_LAT+2 cycles; stall is high for MEM_LAT+1 of them.
//      - No back-to-back issue: RESP always returns to IDLE, so a new request is seen the next cycle.
//  - Reset:
//      - rst_i=1 in any state: next state IDLE, streak=0, latched regs=0.
//      - All outputs 0, except cpu_stall_o, which follows cpu_req_i.
//  - Reset mid-access: the in-flight access is abandoned, with no RESP or rvalid.
//      - A store already strobed in ISSUE is not undone.
//      - A CPU request still held afterwards is re-arbitrated from IDLE.
//  - A request dropped before its grant is legal and ignored.
//  - A CPU request dropped after its grant is a protocol error; the bench flags it.
// STRUCTURE
//  - Shared include dmem_arb_defs.vh holds:
//      - state encodings IDLE/ISSUE/WAIT/RESP (2 bits);
//      - owner IDs OWN_CPU=0, OWN_DBG=1.
//  - Latency counter width is $clog2(MAX(MEM_LAT,2)); streak counter width is $clog2(MAX_CPU_STREAK+1).
//  - One sub-module is natural: arb_streak_ctr (streak count plus the DBG-override decision).
//  - Everything else, including the FSM, the request latch and the output muxes, is flat in dmem_arbiter.
// TESTING (MEM_LAT=2, MAX_CPU_STREAK=4)
//  1. Reset: rst_i=1 for 2 cycles, all requests 0.
//     -> every output 0, state IDLE.
//  2. CPU load alone: cpu_req=1, we=0, addr=0x10 at cycle 0; mem_rdata_i=0xDEADBEEF at cycle 3.
//     -> mem_en_o=1 in cycle 1 only; stall=1 in cycles 0-2; cpu_rdata_o=0xDEADBEEF with stall=0 in cycle 3.
//  3. DBG write alone: addr=0x20, wdata=0x55 at cycle 0.
//     -> dbg_gnt_o, mem_en_o and mem_we_o in cycle 1 with addr 0x20 / wdata 0x55; dbg_rvalid_o in cycle 3.
//  4. CPU and DBG request together at cycle 0.
//     -> CPU ISSUE in cycle 1, CPU RESP in cycle 3; DBG ISSUE (gnt) in cycle 5, dbg_rvalid_o in cycle 7.
//  5. CPU issues a new request after every RESP while DBG is held.
//     -> 4 CPU accesses, then DBG granted 5th; stall stays high through the DBG access.
//  6. rst_i=1 in cycle 2 of test 2, with cpu_req held.
//     -> no RESP; stall stays 1; fresh ISSUE in the cycle after rst_i falls.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : access sequencer states (IDLE/ISSUE/WAIT/RESP, 2 bits)
//   OWN_CPU/DBG : owner IDs for the access currently in flight
//   max_int     : elaboration-time helper for counter width sizing
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dmem_arbiter_streak_ctr.sv
// arb_streak_ctr: counts consecutive CPU grants made while DBG is waiting
// and decides when DBG overrides the CPU's default priority.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   idle_i        arbiter is in IDLE (the only cycle a grant can happen)
//   cpu_req_i     CPU request
//   dbg_req_i     DBG request
//   dbg_win_o     DBG wins arbitration this cycle (meaningful in IDLE only)
module arb_streak_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic idle_i,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    output logic dbg_win_o
);

    localparam int SW = $clog2(MAX_CPU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          at_max;

    assign at_max    = (streak_q == STREAK_MAX);
    assign dbg_win_o = dbg_req_i & (~cpu_req_i | at_max);

    always_comb begin
        streak_d = streak_q;
        if (idle_i) begin
            // A DBG grant, or an IDLE cycle with nobody waiting on DBG,
            // ends the streak; a CPU grant past a waiting DBG extends it.
            if (!dbg_req_i || dbg_win_o) begin
                streak_d = '0;
            end else if (cpu_req_i && !at_max) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, fixed-latency data memory between the
// pipeline MEM stage (CPU) and a debug/loader port (DBG). One access at a
// time: IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles) -> RESP -> IDLE.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata_i      CPU access request (held until its RESP)
//   cpu_rdata_o, cpu_stall_o     CPU load data (RESP only), pipeline stall
//   dbg_req/we/addr/wdata_i      DBG access request (held until dbg_gnt_o)
//   dbg_gnt_o, dbg_rvalid_o      DBG request consumed / access complete pulses
//   dbg_rdata_o                  DBG read data (with dbg_rvalid_o only)
//   mem_en/we/addr/wdata_o       memory strobes and latched access fields
//   mem_rdata_i                  memory read data, MEM_LAT cycles after ISSUE
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 2,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int LAT_W = $clog2(max_int(MEM_LAT, 2));
    // WAIT lasts MEM_LAT-1 cycles; the down-counter is loaded with one less
    // and RESP follows the cycle it reads zero.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT >= 2) ? MEM_LAT - 2 : 0);

    arb_state_e        state_q,  state_d;
    logic              owner_q,  owner_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [LAT_W-1:0]  lat_q,    lat_d;

    // Output flops, computed from the next state so they are clean decodes.
    logic              en_q,       en_d;
    logic              mwe_q,      mwe_d;
    logic              gnt_q,      gnt_d;
    logic              rvalid_q,   rvalid_d;
    logic              cpu_resp_q, cpu_resp_d;

    logic              dbg_win;

    arb_streak_ctr #(
        .MAX_CPU_STREAK (MAX_CPU_STREAK)
    ) u_streak (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idle_i    (state_q == ST_IDLE),
        .cpu_req_i (cpu_req_i),
        .dbg_req_i (dbg_req_i),
        .dbg_win_o (dbg_win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_d = ST_ISSUE;
                    if (dbg_win) begin
                        owner_d = OWN_DBG;
                        we_d    = dbg_we_i;
                        addr_d  = dbg_addr_i;
                        wdata_d = dbg_wdata_i;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                    end
                end
            end
            ST_ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        en_d       = (state_d == ST_ISSUE);
        mwe_d      = en_d & we_d;
        gnt_d      = en_d & (owner_d == OWN_DBG);
        rvalid_d   = (state_d == ST_RESP) & (owner_d == OWN_DBG);
        cpu_resp_d = (state_d == ST_RESP) & (owner_d == OWN_CPU);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            en_q       <= 1'b0;
            mwe_q      <= 1'b0;
            gnt_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            cpu_resp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            en_q       <= en_d;
            mwe_q      <= mwe_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            cpu_resp_q <= cpu_resp_d;
        end
    end

    // Stall is combinational on cpu_req_i so a new request freezes the
    // pipeline in the very cycle it appears, including while DBG is served.
    assign cpu_stall_o  = cpu_req_i & ~cpu_resp_q;
    assign cpu_rdata_o  = cpu_resp_q ? mem_rdata_i : '0;
    assign dbg_gnt_o    = gnt_q;
    assign dbg_rvalid_o = rvalid_q;
    assign dbg_rdata_o  = rvalid_q ? mem_rdata_i : '0;
    assign mem_en_o     = en_q;
    assign mem_we_o     = mwe_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;

endmodule
